mem_responder: RTL and testbench

//  Slave end of the CPU memory interface: word-organised RAM that serves requests from the

---
 rtl/mem_responder_pkg.sv | 18 +
 rtl/mem_responder_if.sv | 24 ++
 rtl/mem_responder_lane_align.sv | 43 ++++
 rtl/mem_responder.sv | 117 +++++++++++
 tb/tb_mem_responder.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and limits for the memory responder: access sizes, FSM states, wait-state ceiling.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_WORD = 2'b00,
    MEM_HALF = 2'b01,
    MEM_BYTE = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } mem_state_t;

  localparam int MEM_MAX_WAIT = 15;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the CPU datapath (master) and the memory responder (slave).
interface mem_responder_if;

  logic        Req;
  logic        Wr;
  logic [1:0]  Size;
  logic [31:0] Address;
  logic [31:0] Datain;
  logic [31:0] Dataout;
  logic        Ack;
  logic        Busy;
  logic        Err;

  modport master (
    output Req, Wr, Size, Address, Datain,
    input  Dataout, Ack, Busy, Err
  );

  modport slave (
    input  Req, Wr, Size, Address, Datain,
    output Dataout, Ack, Busy, Err
  );

endinterface

// File: rtl/mem_responder_lane_align.sv
// Little-endian lane steering for word/half/byte accesses; zero-extends load data.
// Misalignment detection is active only when MEM_MISALIGN_TRAP_EN is defined.
import mem_pkg::*;

module mem_lane_align (
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        misalign
);

  always_comb begin
    be    = 4'b1111;
    wword = wdata;
    rdata = rword;
    if (size == MEM_HALF) begin
      be    = addr_lo[1] ? 4'b1100 : 4'b0011;
      wword = {2{wdata[15:0]}};
      rdata = {16'h0, (addr_lo[1] ? rword[31:16] : rword[15:0])};
    end else if (size == MEM_BYTE) begin
      wword = {4{wdata[7:0]}};
      case (addr_lo)
        2'd0:    begin be = 4'b0001; rdata = {24'h0, rword[7:0]};   end
        2'd1:    begin be = 4'b0010; rdata = {24'h0, rword[15:8]};  end
        2'd2:    begin be = 4'b0100; rdata = {24'h0, rword[23:16]}; end
        default: begin be = 4'b1000; rdata = {24'h0, rword[31:24]}; end
      endcase
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // Size 2'b11 is a word access, so it shares the word alignment rule.
  assign misalign = (size == MEM_BYTE) ? 1'b0 :
                    (size == MEM_HALF) ? addr_lo[0] : (addr_lo != 2'b00);
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: rtl/mem_responder.sv
// Word-organised RAM slave with req/ack handshake and programmable wait states.
// Optional misaligned-access trap: define MEM_MISALIGN_TRAP_EN.
import mem_pkg::*;

module mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  mem_responder_if.slave   bus
);

  localparam int          IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WS_CNT = 4'(WAIT_STATES);

  if (WAIT_STATES < 0 || WAIT_STATES > MEM_MAX_WAIT) begin : g_bad_wait
    $error("WAIT_STATES out of range");
  end

  mem_state_t          state, state_nxt;
  logic [3:0]          cnt_q, cnt_nxt;
  logic                accept;

  logic                wr_q;
  logic [1:0]          size_q;
  logic [IDX_W+1:0]    addr_q;
  logic [31:0]         din_q;
  logic [31:0]         dout_q;

  logic [31:0]         mem [DEPTH_WORDS];
  logic [31:0]         rword;
  logic [3:0]          be;
  logic [31:0]         wword;
  logic [31:0]         rdata;
  logic                misalign;
  logic                resp;
  logic [31:0]         load_data;

  assign rword = mem[addr_q[IDX_W+1:2]];

  mem_lane_align u_align (
    .size     (size_q),
    .addr_lo  (addr_q[1:0]),
    .wdata    (din_q),
    .rword    (rword),
    .be       (be),
    .wword    (wword),
    .rdata    (rdata),
    .misalign (misalign)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_q;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Req) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = WS_CNT;
          end
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) state_nxt = RESP;
        else               cnt_nxt   = cnt_q - 4'd1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      cnt_q  <= 4'd0;
      dout_q <= 32'h0;
    end else begin
      state <= state_nxt;
      cnt_q <= cnt_nxt;
      if (resp && !wr_q) dout_q <= load_data;
    end
  end

  // Request capture: inputs only matter on the accept edge.
  always_ff @(posedge Clk) begin
    if (accept) begin
      wr_q   <= bus.Wr;
      size_q <= bus.Size;
      addr_q <= bus.Address[IDX_W+1:0];
      din_q  <= bus.Datain;
    end
  end

  // Masked store commits at the end of RESP unless trapped or aborted by reset.
  always_ff @(posedge Clk) begin
    if (resp && wr_q && !misalign && !Reset) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr_q[IDX_W+1:2]][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  assign resp      = (state == RESP);
  assign load_data = misalign ? 32'h0 : rdata;

  assign bus.Ack     = resp && !Reset;
  assign bus.Err     = resp && misalign && !Reset;
  assign bus.Busy    = (state != IDLE);
  assign bus.Dataout = (resp && !wr_q) ? load_data : dout_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: random and directed accesses against a byte-level RAM model.
module tb_mem_responder;
  import mem_pkg::*;

  localparam int WS    = 1;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_responder_if bus ();
  mem_responder_if bus0 ();

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .Clk(clk), .Reset(rst), .bus(bus)
  );
  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
    .Clk(clk), .Reset(rst), .bus(bus0)
  );

  typedef struct {
    logic        is_load;
    logic [31:0] data;
    logic        err;
    int          cyc;
    string       name;
  } exp_t;

  exp_t        q[$];
  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_dout = 32'h0;
  int          n_chk  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  logic        prev_ack = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic mis_f(input logic [1:0] size, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
    if (size == 2'b10) return 1'b0;
    if (size == 2'b01) return a[0];
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int unsigned idx_f(input logic [31:0] a);
    return (int'(a >> 2)) % DEPTH;
  endfunction

  function automatic logic [31:0] load_f(input logic [1:0] size, input logic [31:0] a);
    logic [31:0] w = model_mem[idx_f(a)];
    case (size)
      2'b01:   return (w >> (16 * a[1])) & 32'h0000FFFF;
      2'b10:   return (w >> (8 * a[1:0])) & 32'h000000FF;
      default: return w;
    endcase
  endfunction

  task automatic store_m(input logic [1:0] size, input logic [31:0] a, input logic [31:0] d);
    int unsigned i = idx_f(a);
    logic [31:0] mask;
    logic [31:0] val;
    case (size)
      2'b01:   begin mask = 32'hFFFF << (16 * a[1]);  val = (d & 32'hFFFF) << (16 * a[1]);  end
      2'b10:   begin mask = 32'hFF << (8 * a[1:0]);   val = (d & 32'hFF) << (8 * a[1:0]);     end
      default: begin mask = 32'hFFFFFFFF;             val = d;                                 end
    endcase
    model_mem[i] = (model_mem[i] & ~mask) | val;
  endtask

  task automatic txn(input logic wr, input logic [1:0] size, input logic [31:0] a,
                     input logic [31:0] d, input string name);
    exp_t e;
    int   busy_n = 0;
    bit   done   = 0;
    @(posedge clk); #1;
    bus.Req = 1'b1; bus.Wr = wr; bus.Size = size; bus.Address = a; bus.Datain = d;
    e.is_load = !wr;
    e.name    = name;
    e.cyc     = cyc;
    e.err     = mis_f(size, a);
    if (e.err)      e.data = wr ? model_dout : 32'h0;
    else if (!wr)   e.data = load_f(size, a);
    else begin
      e.data = model_dout;
      store_m(size, a, d);
    end
    if (!wr) model_dout = e.data;
    q.push_back(e);
    @(posedge clk); #1;
    bus.Req = 1'b0; bus.Wr = 1'($urandom); bus.Size = 2'($urandom);
    bus.Address = $urandom; bus.Datain = $urandom;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus.Busy) busy_n++;
      else          done = 1;
    end
    chk({name, " busy_cycles"}, 32'(busy_n), 32'(WS + 1));
  endtask

  // Response monitor: pops the oldest expectation on every Ack.
  always @(negedge clk) begin
    exp_t e;
    if (bus.Ack) begin
      chk("ack_back_to_back", 32'(prev_ack), 32'h0);
      if (q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_ack: got ack at cycle %0d expected none", cyc);
      end else begin
        e = q.pop_front();
        chk({e.name, " latency"}, 32'(cyc - e.cyc), 32'(WS + 1));
        chk({e.name, " err"}, 32'(bus.Err), 32'(e.err));
        chk({e.name, " dataout"}, bus.Dataout, e.data);
      end
    end else begin
      chk("err_outside_ack", 32'(bus.Err), 32'h0);
    end
    prev_ack = bus.Ack;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.Req = 1'b0; bus.Wr = 1'b0; bus.Size = 2'b00; bus.Address = '0; bus.Datain = '0;
    bus0.Req = 1'b0; bus0.Wr = 1'b0; bus0.Size = 2'b00; bus0.Address = '0; bus0.Datain = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset ack", 32'(bus.Ack), 32'h0);
    chk("reset busy", 32'(bus.Busy), 32'h0);
    chk("reset err", 32'(bus.Err), 32'h0);
    chk("reset dataout", bus.Dataout, 32'h0);

    for (int i = 0; i < DEPTH; i++) txn(1'b1, 2'b00, 32'(i * 4), $urandom, "init");

    txn(1'b1, 2'b00, 32'h10, 32'hDEADBEEF, "t1 st_word");
    txn(1'b0, 2'b00, 32'h10, 32'h0, "t1 ld_word");
    txn(1'b1, 2'b10, 32'h13, 32'hFFFFFF11, "t2 st_byte");
    txn(1'b0, 2'b00, 32'h10, 32'h0, "t2 ld_word");
    txn(1'b0, 2'b10, 32'h12, 32'h0, "t2 ld_byte");
    txn(1'b0, 2'b01, 32'h12, 32'h0, "t2 ld_half");
    txn(1'b0, 2'b11, 32'h10, 32'h0, "t2 ld_size3");

    // Abort a store in WAIT, then another in RESP.
    txn(1'b1, 2'b00, 32'h20, 32'hA5A5A5A5, "t4 pre");
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      bus.Req = 1'b1; bus.Wr = 1'b1; bus.Size = 2'b00;
      bus.Address = 32'h20; bus.Datain = 32'h12345678;
      @(posedge clk); #1;
      bus.Req = 1'b0;
      if (k == 1) begin
        @(posedge clk); #1;
      end
      rst = 1'b1;
      @(negedge clk);
      chk("t4 ack_in_reset", 32'(bus.Ack), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t4 ack_after", 32'(bus.Ack), 32'h0);
      chk("t4 busy_after", 32'(bus.Busy), 32'h0);
      chk("t4 err_after", 32'(bus.Err), 32'h0);
      chk("t4 dout_after", bus.Dataout, 32'h0);
      model_dout = 32'h0;
    end
    txn(1'b0, 2'b00, 32'h20, 32'h0, "t4 ld_word");

    txn(1'b1, 2'b00, 32'h400, 32'hCAFEF00D, "t5 st_wrap");
    txn(1'b0, 2'b00, 32'h000, 32'h0, "t5 ld_wrap");

    txn(1'b0, 2'b01, 32'h11, 32'h0, "t6 ld_half_mis");
    txn(1'b1, 2'b01, 32'h11, 32'h0000BEEF, "t6 st_half_mis");
    txn(1'b0, 2'b00, 32'h10, 32'h0, "t6 ld_word");
    txn(1'b1, 2'b00, 32'h16, 32'h01020304, "t6 st_word_mis");
    txn(1'b0, 2'b00, 32'h14, 32'h0, "t6 ld_word2");

    for (int i = 0; i < 200; i++) begin
      logic [31:0] a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & 32'h0000_07FF;
      txn(1'($urandom), 2'($urandom), a, $urandom, "rand");
    end

    // Zero-wait-state instance with Req held high: accept and RESP alternate.
    @(posedge clk); #1;
    bus0.Req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3 ack_pattern", 32'(bus0.Ack), 32'(i % 2));
      chk("t3 busy_pattern", 32'(bus0.Busy), 32'(i % 2));
    end
    @(posedge clk); #1;
    bus0.Req = 1'b0;

    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
